// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: stage-status inputs and pipeline-register controls
// exchanged between the 5-stage datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             halt_req;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, mem_err, stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, mem_err, stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch squashes, data-memory waits with a
// timeout, and an orderly drain on halt. Control outputs are combinational
// from the registered state plus the current stage inputs.
// Optional build macro HAZARD_PERF_CNT_EN: builds the saturating performance
// counters; when undefined the counter outputs are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [DRN_W-1:0]  DRN_LAST   = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRN_W-1:0]  DRN_ONE    = DRN_W'(1);

  // Control vector bit order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] CTRL_RUN    = 7'b1111100;
  localparam logic [6:0] CTRL_FREEZE = 7'b0000000;
  localparam logic [6:0] CTRL_RESET  = 7'b0000011;
  localparam logic [6:0] CTRL_HALT   = 7'b0111110;
  localparam logic [6:0] CTRL_SQUASH = 7'b1111111;
  localparam logic [6:0] CTRL_BUBBLE = 7'b0011101;
  localparam logic [6:0] CTRL_DRAIN  = 7'b0011111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [DRN_W-1:0]  drain_cnt_q;
  logic              halted_q;
  logic              mem_err_q;

  logic [6:0] ctrl_s;
  logic       mem_busy_s;
  logic       load_use_s;
  logic       frozen_s;   // pipeline frozen by an outstanding memory access
  logic       bubble_s;   // load-use bubble inserted this cycle
  logic       squash_s;   // taken-branch squash applied this cycle
  logic       halt_go_s;  // halt accepted, drain starts next cycle

  assign mem_busy_s = bus.dmem_req && !bus.dmem_ready;
  assign load_use_s = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Decode the pipeline controls and event strobes for the current cycle.
  always_comb begin
    ctrl_s    = CTRL_RUN;
    frozen_s  = 1'b0;
    bubble_s  = 1'b0;
    squash_s  = 1'b0;
    halt_go_s = 1'b0;
    if (rst) begin
      ctrl_s = CTRL_RESET;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          // Once waiting, only dmem_ready releases the freeze; in RUN a new
          // stall needs an actual pending request.
          if ((state_q == MEM_WAIT) ? !bus.dmem_ready : mem_busy_s) begin
            ctrl_s   = CTRL_FREEZE;
            frozen_s = 1'b1;
          end else if (bus.halt_req) begin
            ctrl_s    = CTRL_HALT;
            halt_go_s = 1'b1;
          end else if (bus.ex_branch_taken) begin
            ctrl_s   = CTRL_SQUASH;
            squash_s = 1'b1;
          end else if (load_use_s) begin
            ctrl_s   = CTRL_BUBBLE;
            bubble_s = 1'b1;
          end else begin
            ctrl_s = CTRL_RUN;
          end
        end
        DRAIN: begin
          if (mem_busy_s) begin
            ctrl_s   = CTRL_FREEZE;
            frozen_s = 1'b1;
          end else begin
            ctrl_s = CTRL_DRAIN;
          end
        end
        HALTED:  ctrl_s = CTRL_FREEZE;
        default: ctrl_s = CTRL_FREEZE;
      endcase
    end
  end

  // Sequencer state, wait/drain counters and the sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= {WAIT_W{1'b0}};
      drain_cnt_q <= {DRN_W{1'b0}};
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (frozen_s) begin
            if (state_q == RUN) begin
              state_q    <= MEM_WAIT;
              wait_cnt_q <= WAIT_ONE;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
              mem_err_q <= 1'b1;
              state_q   <= HALTED;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_ONE;
            end
          end else begin
            wait_cnt_q <= {WAIT_W{1'b0}};
            if (halt_go_s) begin
              state_q     <= DRAIN;
              drain_cnt_q <= {DRN_W{1'b0}};
            end else begin
              state_q <= RUN;
            end
          end
        end
        DRAIN: begin
          if (frozen_s) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
              mem_err_q <= 1'b1;
              state_q   <= HALTED;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_ONE;
            end
          end else begin
            wait_cnt_q <= {WAIT_W{1'b0}};
            if (drain_cnt_q == DRN_LAST) begin
              halted_q <= 1'b1;
              state_q  <= HALTED;
            end else begin
              drain_cnt_q <= drain_cnt_q + DRN_ONE;
            end
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc_en      = ctrl_s[6];
  assign bus.ifid_en    = ctrl_s[5];
  assign bus.idex_en    = ctrl_s[4];
  assign bus.exmem_en   = ctrl_s[3];
  assign bus.memwb_en   = ctrl_s[2];
  assign bus.ifid_flush = ctrl_s[1];
  assign bus.idex_flush = ctrl_s[0];
  assign bus.halted     = halted_q;
  assign bus.mem_err    = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] memwait_cnt_q;

  // Saturating event counters for bubbles, squashes and frozen memory cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= {CNT_W{1'b0}};
      flush_cnt_q   <= {CNT_W{1'b0}};
      memwait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (bubble_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (squash_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
      if (frozen_s && (memwait_cnt_q != CNT_MAX)) begin
        memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.memwait_cnt = memwait_cnt_q;
`else
  // Event strobes only feed the counters; without them they are unused.
  logic perf_unused_s;
  assign perf_unused_s   = bubble_s ^ squash_s;
  assign bus.stall_cnt   = {CNT_W{1'b0}};
  assign bus.flush_cnt   = {CNT_W{1'b0}};
  assign bus.memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN_CYCLES = 4;
  localparam int TIMEOUT      = 16;
  localparam int CNT_W        = 16;
  localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(hif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
            hif.ifid_flush, hif.idex_flush};
  endfunction

  function automatic longint sat(input longint v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 waiting on memory, 2 draining, 3 stopped for good
  int     m_mode = 0;
  int     m_frozen = 0;   // consecutive memory-frozen cycles
  int     m_drained = 0;  // advancing drain cycles done
  bit     m_halted = 1'b0;
  bit     m_err = 1'b0;
  longint m_stall = 0, m_flush = 0, m_memwait = 0;

  // Compare every cycle, then advance the model as the coming edge will.
  always @(negedge clk) begin : cmp
    logic [6:0] e;
    int nmode, nfroz, ndr;
    bit nh, ne, waiting, lu;
    longint ns, nf, nw;
    nmode = m_mode; nfroz = m_frozen; ndr = m_drained;
    nh = m_halted; ne = m_err; ns = m_stall; nf = m_flush; nw = m_memwait;
    lu = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
         ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
          (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
    if (rst) begin
      e = 7'b0000011;
      nmode = 0; nfroz = 0; ndr = 0; nh = 1'b0; ne = 1'b0; ns = 0; nf = 0; nw = 0;
    end else if (m_mode == 3) begin
      e = 7'b0000000;
    end else begin
      waiting = (m_mode == 1) ? !hif.dmem_ready : (hif.dmem_req && !hif.dmem_ready);
      if (waiting) begin
        e = 7'b0000000;
        nfroz = m_frozen + 1;
        nw = sat(m_memwait + 1);
        if (nfroz > TIMEOUT) begin ne = 1'b1; nmode = 3; end
        else if (m_mode == 0) nmode = 1;
      end else if (m_mode == 2) begin
        e = 7'b0011111;
        nfroz = 0;
        ndr = m_drained + 1;
        if (ndr == DRAIN_CYCLES) begin nh = 1'b1; nmode = 3; end
      end else begin
        nfroz = 0; nmode = 0;
        if (hif.halt_req) begin e = 7'b0111110; nmode = 2; ndr = 0; end
        else if (hif.ex_branch_taken) begin e = 7'b1111111; nf = sat(m_flush + 1); end
        else if (lu) begin e = 7'b0011101; ns = sat(m_stall + 1); end
        else e = 7'b1111100;
      end
    end
    check("ctrl", 64'(ctrl_now()), 64'(e));
    check("halted", 64'(hif.halted), 64'(m_halted));
    check("mem_err", 64'(hif.mem_err), 64'(m_err));
    check("stall_cnt", 64'(hif.stall_cnt), PERF ? 64'(m_stall) : 64'd0);
    check("flush_cnt", 64'(hif.flush_cnt), PERF ? 64'(m_flush) : 64'd0);
    check("memwait_cnt", 64'(hif.memwait_cnt), PERF ? 64'(m_memwait) : 64'd0);
    m_mode = nmode; m_frozen = nfroz; m_drained = ndr; m_halted = nh; m_err = ne;
    m_stall = ns; m_flush = nf; m_memwait = nw;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.ex_rd = 5'd0; hif.ex_mem_read = 1'b0; hif.ex_branch_taken = 1'b0;
    hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0; hif.halt_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_x5();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_uses_rs1 = 1'b1; hif.id_rs1 = 5'd5;
  endtask

  int k;
  int dead_run;
  int ready_bias;

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    check("rst_ctrl", 64'(ctrl_now()), 64'(7'b0000011));
    step(); rst = 1'b0;
    @(negedge clk);
    check("run_ctrl", 64'(ctrl_now()), 64'(7'b1111100));

    // load-use on x5: one bubble, then free running
    step(); load_use_x5();
    @(negedge clk);
    check("lu_ctrl", 64'(ctrl_now()), 64'(7'b0011101));
    step(); idle();
    @(negedge clk);
    check("lu_after", 64'(ctrl_now()), 64'(7'b1111100));

    // load to x0 never stalls
    step(); load_use_x5(); hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0;
    @(negedge clk);
    check("lu_x0", 64'(ctrl_now()), 64'(7'b1111100));

    // branch beats load-use
    step(); load_use_x5(); hif.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_lu_ctrl", 64'(ctrl_now()), 64'(7'b1111111));
    step(); idle();
    @(negedge clk);
    check("br_stall_cnt", 64'(hif.stall_cnt), PERF ? 64'd1 : 64'd0);
    check("br_flush_cnt", 64'(hif.flush_cnt), PERF ? 64'd1 : 64'd0);

    // three-cycle memory wait
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_frozen", 64'(ctrl_now()), 64'(7'b0000000));
      step();
    end
    hif.dmem_ready = 1'b1;
    @(negedge clk);
    check("mw_ready", 64'(ctrl_now()), 64'(7'b1111100));
    step(); idle();
    @(negedge clk);
    check("mw_cnt", 64'(hif.memwait_cnt), PERF ? 64'd3 : 64'd0);

    // halt with a 2-cycle stall in the middle of the drain
    step(); hif.halt_req = 1'b1;
    @(negedge clk);
    check("halt_req_ctrl", 64'(ctrl_now()), 64'(7'b0111110));
    for (int i = 1; i <= 6; i++) begin
      step(); idle();
      if (i == 3 || i == 4) begin hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0; end
      @(negedge clk);
      check("drain_pc_en", 64'(hif.pc_en), 64'd0);
      check("drain_halted", 64'(hif.halted), 64'd0);
    end
    step(); idle();
    @(negedge clk);
    check("halted_rise", 64'(hif.halted), 64'd1);
    check("halted_ctrl", 64'(ctrl_now()), 64'(7'b0000000));
    check("halt_memwait", 64'(hif.memwait_cnt), PERF ? 64'd5 : 64'd0);

    // memory timeout
    step(); rst = 1'b1;
    step(); rst = 1'b0; hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (hif.mem_err === 1'b1) begin k = i; break; end
      step();
    end
    check("timeout_cycle", 64'(k), 64'(TIMEOUT + 2));
    check("timeout_halted", 64'(hif.halted), 64'd0);
    step(); hif.dmem_ready = 1'b1;
    @(negedge clk);
    check("timeout_stuck", 64'(ctrl_now()), 64'(7'b0000000));

    // reset in the middle of a memory wait
    step(); rst = 1'b1; idle();
    step(); rst = 1'b0; hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    step(); step(); step(); rst = 1'b1;
    step(); rst = 1'b0; idle();
    @(negedge clk);
    check("rst_wait_ctrl", 64'(ctrl_now()), 64'(7'b1111100));
    check("rst_wait_cnt", 64'(hif.memwait_cnt), 64'd0);
    check("rst_wait_err", 64'(hif.mem_err), 64'd0);

    // randomized traffic
    dead_run = 0;
    ready_bias = 5;
    for (int c = 0; c < 4000; c++) begin
      step();
      if ((c % 64) == 0) ready_bias = int'($urandom_range(0, 9));
      rst = ($urandom_range(0, 299) == 0) || (dead_run > 5);
      hif.id_rs1          = 5'($urandom_range(0, 3));
      hif.id_rs2          = 5'($urandom_range(0, 3));
      hif.id_uses_rs1     = ($urandom_range(0, 1) == 1);
      hif.id_uses_rs2     = ($urandom_range(0, 1) == 1);
      hif.ex_rd           = 5'($urandom_range(0, 3));
      hif.ex_mem_read     = ($urandom_range(0, 2) == 0);
      hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
      hif.dmem_req        = ($urandom_range(0, 3) == 0);
      hif.dmem_ready      = (int'($urandom_range(0, 9)) < ready_bias);
      hif.halt_req        = ($urandom_range(0, 39) == 0);
      if (m_mode == 3) dead_run++;
      else dead_run = 0;
    end
    step(); idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
